// File: rtl/prach_pkt_rx.sv
// prach_pkt_rx: store-and-forward receiver for the PRACH AVST stream.
// Packets are buffered until eop; framing errors roll the buffer back so only good packets are forwarded.
module prach_pkt_rx #(
  parameter int DEPTH     = 512,
  parameter int MAX_WORDS = 256
) (
  input  logic         clk_eth_xran,
  input  logic         rst_eth_xran,
  input  logic [127:0] avst_sink_data,
  input  logic         avst_sink_valid,
  input  logic [15:0]  avst_sink_channel,
  input  logic         avst_sink_startofpacket,
  input  logic         avst_sink_endofpacket,
  output logic         avst_sink_ready,
  output logic [127:0] m_data,
  output logic [15:0]  m_channel,
  output logic         m_sop,
  output logic         m_eop,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  pkt_ok_cnt,
  output logic [31:0]  pkt_err_cnt,
  output logic [3:0]   err_flags,
  input  logic         err_clr
);
  // state     | meaning
  // S_IDLE    | between packets, next accepted beat must carry sop
  // S_PKT     | collecting a packet into the speculative region of the buffer
  // S_DISCARD | dropping the tail of a rejected packet until eop or a new sop

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_WORDS + 1);
  localparam int WW = 128 + 16 + 2;

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_DISCARD} state_t;
  state_t state, state_nx;

  logic [WW-1:0] mem [DEPTH];
  logic [PW-1:0] wr, wc, rd, fp, cm_ptr, wc_eff, wr_nx, base, commit_ptr;
  logic          cm_pend, commit, do_start, we, acc, full, ld;
  logic [AW-1:0] waddr;
  logic [LW-1:0] len, len_nx;
  logic [15:0]   chan, chan_nx;
  logic          err_ev, ok_q, err_q;
  logic [3:0]    flag_ev, flag_q;

  // fp is the fetch pointer into the output register; rd only moves when a word leaves,
  // so the word parked in the output register still occupies buffer space.
  assign full            = (wr - rd) == PW'(DEPTH);
  assign avst_sink_ready = !rst_eth_xran && (state == S_DISCARD || !full);
  assign acc             = avst_sink_valid && avst_sink_ready;
  assign wc_eff          = cm_pend ? cm_ptr : wc;
  assign ld              = (fp != wc) && (!m_valid || m_ready);

  always_comb begin
    state_nx   = state;
    wr_nx      = wr;
    len_nx     = len;
    chan_nx    = chan;
    we         = 1'b0;
    waddr      = wr[AW-1:0];
    commit     = 1'b0;
    commit_ptr = wr;
    err_ev     = 1'b0;
    flag_ev    = 4'b0000;
    do_start   = 1'b0;
    base       = wr;
    if (acc) begin
      case (state)
        S_IDLE: begin
          if (avst_sink_startofpacket) begin
            do_start = 1'b1;
          end else begin
            err_ev  = 1'b1;
            flag_ev = 4'b0001;
          end
        end
        S_PKT: begin
          if (avst_sink_startofpacket) begin
            err_ev   = 1'b1;
            flag_ev  = 4'b0010;
            do_start = 1'b1;
            base     = wc_eff;
          end else if (avst_sink_channel != chan || len == LW'(MAX_WORDS)) begin
            err_ev   = 1'b1;
            flag_ev  = (avst_sink_channel != chan) ? 4'b0100 : 4'b1000;
            wr_nx    = wc_eff;
            state_nx = avst_sink_endofpacket ? S_IDLE : S_DISCARD;
          end else begin
            we    = 1'b1;
            wr_nx = wr + 1'b1;
            if (avst_sink_endofpacket) begin
              commit     = 1'b1;
              commit_ptr = wr + 1'b1;
              state_nx   = S_IDLE;
            end else begin
              len_nx = len + 1'b1;
            end
          end
        end
        S_DISCARD: begin
          if (avst_sink_startofpacket) begin
            do_start = 1'b1;
          end else if (avst_sink_endofpacket) begin
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
      if (do_start) begin
        we      = 1'b1;
        waddr   = base[AW-1:0];
        wr_nx   = base + 1'b1;
        chan_nx = avst_sink_channel;
        len_nx  = LW'(1);
        if (avst_sink_endofpacket) begin
          commit     = 1'b1;
          commit_ptr = base + 1'b1;
          state_nx   = S_IDLE;
        end else begin
          state_nx = S_PKT;
        end
      end
    end
  end

  always_ff @(posedge clk_eth_xran) begin
    if (we) mem[waddr] <= {avst_sink_data, avst_sink_channel,
                           avst_sink_startofpacket, avst_sink_endofpacket};
  end

  always_ff @(posedge clk_eth_xran) begin
    if (rst_eth_xran) begin
      state       <= S_IDLE;
      wr          <= '0;
      wc          <= '0;
      rd          <= '0;
      fp          <= '0;
      cm_pend     <= 1'b0;
      cm_ptr      <= '0;
      len         <= '0;
      chan        <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      flag_q      <= '0;
      pkt_ok_cnt  <= '0;
      pkt_err_cnt <= '0;
      err_flags   <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_channel   <= '0;
      m_sop       <= 1'b0;
      m_eop       <= 1'b0;
    end else begin
      state   <= state_nx;
      wr      <= wr_nx;
      len     <= len_nx;
      chan    <= chan_nx;
      cm_pend <= commit;
      cm_ptr  <= commit_ptr;
      if (cm_pend) wc <= cm_ptr;
      ok_q        <= commit;
      err_q       <= err_ev;
      flag_q      <= flag_ev;
      pkt_ok_cnt  <= pkt_ok_cnt + {31'd0, ok_q};
      pkt_err_cnt <= pkt_err_cnt + {31'd0, err_q};
      err_flags   <= (err_clr ? 4'b0000 : err_flags) | flag_q;
      if (m_valid && m_ready) rd <= rd + 1'b1;
      if (ld) begin
        {m_data, m_channel, m_sop, m_eop} <= mem[fp[AW-1:0]];
        fp      <= fp + 1'b1;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prach_pkt_rx.sv
// tb_prach_pkt_rx: directed bench for prach_pkt_rx with hand-derived expectations.
// Output beats are captured at the falling edge and compared against a queue of expected words.
module tb_prach_pkt_rx;
  logic         clk_eth_xran = 1'b0;
  logic         rst_eth_xran = 1'b1;
  logic [127:0] avst_sink_data = '0;
  logic         avst_sink_valid = 1'b0;
  logic [15:0]  avst_sink_channel = '0;
  logic         avst_sink_startofpacket = 1'b0;
  logic         avst_sink_endofpacket = 1'b0;
  logic         avst_sink_ready;
  logic [127:0] m_data;
  logic [15:0]  m_channel;
  logic         m_sop, m_eop, m_valid;
  logic         m_ready = 1'b1;
  logic [31:0]  pkt_ok_cnt, pkt_err_cnt;
  logic [3:0]   err_flags;
  logic         err_clr = 1'b0;

  prach_pkt_rx #(.DEPTH(512), .MAX_WORDS(256)) dut (
    .clk_eth_xran            (clk_eth_xran),
    .rst_eth_xran            (rst_eth_xran),
    .avst_sink_data          (avst_sink_data),
    .avst_sink_valid         (avst_sink_valid),
    .avst_sink_channel       (avst_sink_channel),
    .avst_sink_startofpacket (avst_sink_startofpacket),
    .avst_sink_endofpacket   (avst_sink_endofpacket),
    .avst_sink_ready         (avst_sink_ready),
    .m_data                  (m_data),
    .m_channel               (m_channel),
    .m_sop                   (m_sop),
    .m_eop                   (m_eop),
    .m_valid                 (m_valid),
    .m_ready                 (m_ready),
    .pkt_ok_cnt              (pkt_ok_cnt),
    .pkt_err_cnt             (pkt_err_cnt),
    .err_flags               (err_flags),
    .err_clr                 (err_clr)
  );

  always #5 clk_eth_xran = ~clk_eth_xran;

  int n_chk = 0;
  int n_fail = 0;
  int exp_ok = 0;
  int exp_err = 0;
  int unsigned seq = 0;
  logic [145:0] got_q[$];
  logic [145:0] exp_q[$];

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int unsigned s);
    return {s, ~s, s ^ 32'h5a5a_5a5a, 32'hc0de_0000 ^ s};
  endfunction

  always @(negedge clk_eth_xran)
    if (m_valid && m_ready) got_q.push_back({m_data, m_channel, m_sop, m_eop});

  // Presents one beat and holds it until accepted; time is left at posedge+1.
  task automatic beat(input logic [15:0] ch, input logic s, input logic e, input bit keep);
    int w;
    seq++;
    avst_sink_data          = mk(seq);
    avst_sink_channel       = ch;
    avst_sink_startofpacket = s;
    avst_sink_endofpacket   = e;
    avst_sink_valid         = 1'b1;
    @(negedge clk_eth_xran);
    w = 0;
    while (!avst_sink_ready && w < 200) begin
      @(negedge clk_eth_xran);
      w++;
    end
    if (w == 200) chk("ready_wait", {159'd0, avst_sink_ready}, 160'd1);
    @(posedge clk_eth_xran);
    #1;
    avst_sink_valid = 1'b0;
    if (keep) exp_q.push_back({mk(seq), ch, s, e});
  endtask

  task automatic pkt(input logic [15:0] ch, input int n, input bit keep);
    for (int i = 0; i < n; i++) beat(ch, i == 0, i == n - 1, keep);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_eth_xran);
    #1;
  endtask

  task automatic clr_flags();
    err_clr = 1'b1;
    @(posedge clk_eth_xran);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_ok"}, pkt_ok_cnt, exp_ok);
    chk({tag, "_err"}, pkt_err_cnt, exp_err);
  endtask

  task automatic drain_check(input string tag);
    int w;
    w = 0;
    while (got_q.size() < exp_q.size() && w < 3000) begin
      @(negedge clk_eth_xran);
      w++;
    end
    idle(4);
    chk({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit stop;

    // Reset state
    repeat (3) @(posedge clk_eth_xran);
    @(negedge clk_eth_xran);
    chk("rst_ready", avst_sink_ready, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_mside", {m_channel, m_sop, m_eop}, 0);
    chk("rst_ok", pkt_ok_cnt, 0);
    chk("rst_err", pkt_err_cnt, 0);
    chk("rst_flags", err_flags, 0);
    @(posedge clk_eth_xran);
    #1;
    rst_eth_xran = 1'b0;
    @(negedge clk_eth_xran);
    chk("ready_after_rst", avst_sink_ready, 1);
    @(posedge clk_eth_xran);
    #1;

    // Single 3-beat packet, latency and counter timing
    beat(16'h0005, 1'b1, 1'b0, 1'b1);
    beat(16'h0005, 1'b0, 1'b0, 1'b1);
    beat(16'h0005, 1'b0, 1'b1, 1'b1);
    exp_ok++;
    @(negedge clk_eth_xran);
    chk("single_ok_lag", pkt_ok_cnt, 0);
    chk("single_mv_n0", m_valid, 0);
    @(negedge clk_eth_xran);
    chk("single_ok_upd", pkt_ok_cnt, 1);
    chk("single_mv_n1", m_valid, 0);
    @(negedge clk_eth_xran);
    chk("single_mv_n2", m_valid, 1);
    chk("single_first", {m_channel, m_sop, m_eop}, {16'h0005, 2'b10});
    @(posedge clk_eth_xran);
    #1;
    drain_check("single");
    chk_cnt("single");

    // Missing EOP: only the trailing sop+eop packet survives
    beat(16'h0007, 1'b1, 1'b0, 1'b0);
    beat(16'h0007, 1'b0, 1'b0, 1'b0);
    beat(16'h0007, 1'b1, 1'b1, 1'b1);
    exp_err++;
    exp_ok++;
    idle(3);
    chk("noeop_flags", err_flags, 4'b0010);
    chk_cnt("noeop");
    drain_check("noeop");
    clr_flags();
    @(negedge clk_eth_xran);
    chk("flag_clear", err_flags, 0);
    @(posedge clk_eth_xran);
    #1;

    // Channel change mid-packet, then a good packet
    beat(16'h0001, 1'b1, 1'b0, 1'b0);
    beat(16'h0001, 1'b0, 1'b0, 1'b0);
    beat(16'h0002, 1'b0, 1'b0, 1'b0);
    beat(16'h0001, 1'b0, 1'b1, 1'b0);
    exp_err++;
    pkt(16'h0003, 2, 1'b1);
    exp_ok++;
    idle(3);
    chk("chan_flags", err_flags, 4'b0100);
    chk_cnt("chan");
    drain_check("chan");
    clr_flags();

    // Overlength 257 beats rejected, 256 beats pass
    pkt(16'h0009, 257, 1'b0);
    exp_err++;
    idle(3);
    chk("ovl_flags", err_flags, 4'b1000);
    chk_cnt("ovl");
    pkt(16'h0009, 256, 1'b1);
    exp_ok++;
    drain_check("max256");
    chk_cnt("max256");
    clr_flags();

    // Backpressure: fill the buffer with 2-beat packets
    m_ready = 1'b0;
    acc = 0;
    stop = 1'b0;
    for (int p = 0; p < 300 && !stop; p++) begin
      for (int b = 0; b < 2 && !stop; b++) begin
        seq++;
        avst_sink_data          = mk(seq);
        avst_sink_channel       = 16'(p);
        avst_sink_startofpacket = (b == 0);
        avst_sink_endofpacket   = (b == 1);
        avst_sink_valid         = 1'b1;
        @(negedge clk_eth_xran);
        if (!avst_sink_ready) begin
          stop = 1'b1;
        end else begin
          exp_q.push_back({mk(seq), 16'(p), b == 0, b == 1});
          @(posedge clk_eth_xran);
          #1;
          acc++;
        end
      end
    end
    avst_sink_valid = 1'b0;
    chk("bp_accepted", acc, 512);
    idle(3);
    @(negedge clk_eth_xran);
    chk("bp_ready_hold", avst_sink_ready, 0);
    chk("bp_mvalid_hold", m_valid, 1);
    @(posedge clk_eth_xran);
    #1;
    m_ready = 1'b1;
    exp_ok += 256;
    drain_check("bp");
    chk_cnt("bp");

    // Orphan beat in IDLE
    beat(16'h0000, 1'b0, 1'b0, 1'b0);
    exp_err++;
    idle(3);
    chk("orphan_flags", err_flags, 4'b0001);
    chk_cnt("orphan");

    // Reset mid-packet, orphan after reset, then a single-beat packet
    beat(16'h0004, 1'b1, 1'b0, 1'b0);
    beat(16'h0004, 1'b0, 1'b0, 1'b0);
    rst_eth_xran = 1'b1;
    idle(2);
    rst_eth_xran = 1'b0;
    got_q.delete();
    exp_q.delete();
    exp_ok = 0;
    exp_err = 0;
    @(negedge clk_eth_xran);
    chk("rst2_flags", err_flags, 0);
    chk("rst2_ready", avst_sink_ready, 1);
    @(posedge clk_eth_xran);
    #1;
    beat(16'h0006, 1'b0, 1'b1, 1'b0);
    exp_err++;
    beat(16'h0006, 1'b1, 1'b1, 1'b1);
    exp_ok++;
    drain_check("rst2");
    chk_cnt("rst2");
    chk("rst2_orphan_flag", err_flags, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
